// File: rtl/board_pkg.sv
// Shared constants, FSM state encoding and pixel payload type for the board redraw controller.
package board_pkg;

    localparam int unsigned GRID_W    = 18;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned ORIGIN_X0 = 37;
    localparam int unsigned ORIGIN_Y0 = 7;

    // Cell codes as stored two bits per cell in the grid word
    localparam logic [1:0] EMPTY    = 2'd0;
    localparam logic [1:0] O        = 2'd1;
    localparam logic [1:0] X        = 2'd2;
    localparam logic [1:0] RESERVED = 2'd3;

    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] LBLUE  = 3'b011;
    localparam logic [2:0] PURPLE = 3'b101;
    localparam logic [2:0] BLACK  = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } board_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

endpackage

// File: rtl/cell_colour_lut.sv
// Maps a 2-bit cell code to its 3-bit VGA colour.
module cell_colour_lut
    import board_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [2:0] colour_c
);

    always_comb begin
        colour_c = BLACK;
        case (code_i)
            EMPTY:    colour_c = WHITE;
            O:        colour_c = LBLUE;
            X:        colour_c = PURPLE;
            RESERVED: colour_c = BLACK;
            default:  colour_c = BLACK;
        endcase
    end

endmodule

// File: rtl/board_redraw_ctrl.sv
// Redraws a 3x3 board as nine filled squares, one pixel per cycle, into a VGA plotter.
// Define BOARD_BORDER_EN to outline every tile in black.
module board_redraw_ctrl
    import board_pkg::*;
#(
    parameter int unsigned TILE_SIZE = 26,
    parameter int unsigned PITCH     = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [GRID_W-1:0] grid,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PIX_W = 5;
    localparam int unsigned IDX_W = 4;

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(TILE_SIZE - 1);
    localparam logic [IDX_W-1:0] CELL_LAST = IDX_W'(NUM_CELLS - 1);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] LOAD  = ST_LOAD;
    localparam logic [2:0] SETUP = ST_SETUP;
    localparam logic [2:0] DRAW  = ST_DRAW;
    localparam logic [2:0] DONE  = ST_DONE;

    logic [2:0]        state_q, state_d;
    logic [GRID_W-1:0] snap_q,  snap_d;
    logic [IDX_W-1:0]  cell_q,  cell_d;
    logic [1:0]        row_q,   row_d;
    logic [1:0]        col_q,   col_d;
    logic [PIX_W-1:0]  px_q,    px_d;
    logic [PIX_W-1:0]  py_q,    py_d;
    logic [7:0]        x0_q,    x0_d;
    logic [6:0]        y0_q,    y0_d;
    pixel_t            pix_q,   pix_d;
    logic              plot_q,  plot_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [1:0]        code_c;
    logic [2:0]        lut_colour_c;

    function automatic logic [7:0] origin_x(input logic [1:0] c);
        case (c)
            2'd0:    origin_x = 8'(ORIGIN_X0);
            2'd1:    origin_x = 8'(ORIGIN_X0 + PITCH);
            default: origin_x = 8'(ORIGIN_X0 + 2 * PITCH);
        endcase
    endfunction

    function automatic logic [6:0] origin_y(input logic [1:0] r);
        case (r)
            2'd0:    origin_y = 7'(ORIGIN_Y0);
            2'd1:    origin_y = 7'(ORIGIN_Y0 + PITCH);
            default: origin_y = 7'(ORIGIN_Y0 + 2 * PITCH);
        endcase
    endfunction

    // Colour comes from the snapshot, so grid changes mid-frame never leak in
    assign code_c = snap_q[{cell_q, 1'b0} +: 2];

    cell_colour_lut u_lut (
        .code_i   (code_c),
        .colour_c (lut_colour_c)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cell_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cell_q  <= cell_d;
            row_q   <= row_d;
            col_q   <= col_d;
            px_q    <= px_d;
            py_q    <= py_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state plus the pixel that will be on the outputs during that state
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cell_d  = cell_q;
        row_d   = row_q;
        col_d   = col_q;
        px_d    = px_q;
        py_d    = py_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                snap_d  = grid;
                cell_d  = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                x0_d    = origin_x(col_q);
                y0_d    = origin_y(row_q);
                px_d    = '0;
                py_d    = '0;
                state_d = DRAW;
            end
            DRAW: begin
                if (px_q != PIX_LAST) begin
                    px_d = px_q + PIX_W'(1);
                end else begin
                    px_d = '0;
                    if (py_q != PIX_LAST) begin
                        py_d = py_q + PIX_W'(1);
                    end else if (cell_q == CELL_LAST) begin
                        state_d = DONE;
                    end else begin
                        cell_d  = cell_q + IDX_W'(1);
                        state_d = SETUP;
                        if (col_q == 2'd2) begin
                            col_d = '0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        if (state_d == DRAW) begin
            plot_d       = 1'b1;
            pix_d.x      = x0_d + 8'(px_d);
            pix_d.y      = y0_d + 7'(py_d);
            pix_d.colour = lut_colour_c;
`ifdef BOARD_BORDER_EN
            if ((px_d == '0) || (px_d == PIX_LAST) || (py_d == '0) || (py_d == PIX_LAST)) begin
                pix_d.colour = BLACK;
            end
`endif
        end
    end

    assign x      = pix_q.x;
    assign y      = pix_q.y;
    assign colour = pix_q.colour;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_board_redraw_ctrl.sv
// Self-checking bench for board_redraw_ctrl: per-frame pixel scoreboard plus corner-case sequences.
module tb_board_redraw_ctrl;

    localparam int unsigned T    = 26;
    localparam int unsigned P    = 30;
    localparam int          LAT  = 1 + 9 * (1 + T * T);
    localparam int          NPIX = 9 * T * T;
    localparam int          LASTX = 37 + 2 * P + T - 1;
    localparam int          LASTY = 7 + 2 * P + T - 1;

    localparam logic [2:0] CW = 3'b111;
    localparam logic [2:0] CB = 3'b011;
    localparam logic [2:0] CP = 3'b101;
    localparam logic [2:0] CK = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pix_t;

    typedef struct packed {
        logic [17:0] grid;
        logic [26:0] cols;
    } vec_t;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [17:0] grid;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    board_redraw_ctrl #(.TILE_SIZE(T), .PITCH(P)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .grid   (grid),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    pix_t       exp_q[$];
    vec_t       vec[4];
    int         n_checks;
    int         n_fail;
    int         pix_cnt;
    int         done_cnt;
    logic [7:0] last_x;
    logic [6:0] last_y;

    function automatic logic [26:0] mk(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                                       input logic [2:0] c3, input logic [2:0] c4, input logic [2:0] c5,
                                       input logic [2:0] c6, input logic [2:0] c7, input logic [2:0] c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [26:0] cols);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int py = 0; py < int'(T); py++)
                    for (int px = 0; px < int'(T); px++) begin
                        pix_t p;
                        p.x      = 8'(37 + int'(P) * c + px);
                        p.y      = 7'(7 + int'(P) * r + py);
                        p.colour = cols[3 * (3 * r + c) +: 3];
`ifdef BOARD_BORDER_EN
                        if (px == 0 || py == 0 || px == int'(T) - 1 || py == int'(T) - 1) p.colour = 3'b000;
`endif
                        exp_q.push_back(p);
                    end
    endtask

    // Pops one expected pixel for every plot strobe
    task automatic monitor();
        forever begin
            @(negedge clock);
            if (done) done_cnt++;
            if (plot) begin
                pix_cnt++;
                last_x = x;
                last_y = y;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel_unexpected: got plot at (%0d,%0d), expected no plot", x, y);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (x !== e.x || y !== e.y || colour !== e.colour) begin
                        n_fail++;
                        $display("FAIL pixel %0d: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                                 pix_cnt, x, y, colour, e.x, e.y, e.colour);
                    end
                end
            end
        end
    endtask

    // Counts negedges (first one is 0) until done; optionally drops start / toggles grid on the way
    task automatic wait_done(input int exp_cycles, input string name, input bit drop_start, input bit toggle);
        int k;
        int busy_low;
        bit seen;
        busy_low = 0;
        seen     = 1'b0;
        for (k = 0; k <= exp_cycles + 50; k++) begin
            @(negedge clock);
            if (drop_start && k == 0) start = 1'b0;
            if (toggle) begin
                if (k == 100)  grid = vec[2].grid;
                if (k == 3000) grid = vec[0].grid;
                if (k == 5000) grid = vec[3].grid;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_low++;
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        chk({name, "_latency"}, k, exp_cycles);
        chk({name, "_busy_low_cycles"}, busy_low, 0);
        chk({name, "_busy_at_done"}, int'(busy), 1);
        chk({name, "_plot_at_done"}, int'(plot), 0);
    endtask

    task automatic frame_end(input string name);
        chk({name, "_plot_count"}, pix_cnt, NPIX);
        chk({name, "_last_x"}, int'(last_x), LASTX);
        chk({name, "_last_y"}, int'(last_y), LASTY);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        @(negedge clock);
        chk({name, "_done_pulse_width"}, int'(done), 0);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic run_frame(input int vi, input string name);
        pix_cnt = 0;
        grid    = vec[vi].grid;
        push_frame(vec[vi].cols);
        start = 1'b1;
        wait_done(LAT, name, 1'b1, 1'b0);
        frame_end(name);
    endtask

    initial begin
        int cyc;
        int d0;
        n_checks = 0;
        n_fail   = 0;
        pix_cnt  = 0;
        done_cnt = 0;
        last_x   = '0;
        last_y   = '0;
        resetn   = 1'b0;
        start    = 1'b0;
        grid     = '0;

        vec[0].grid = 18'h00000; vec[0].cols = mk(CW, CW, CW, CW, CW, CW, CW, CW, CW);
        vec[1].grid = 18'h30201; vec[1].cols = mk(CB, CW, CW, CW, CP, CW, CW, CW, CK);
        vec[2].grid = 18'h15555; vec[2].cols = mk(CB, CB, CB, CB, CB, CB, CB, CB, CB);
        vec[3].grid = 18'h0E4E4; vec[3].cols = mk(CW, CB, CP, CK, CW, CB, CP, CK, CW);

        repeat (2) @(negedge clock);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        fork
            monitor();
        join_none

        resetn = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_busy", int'(busy), 0);
        chk("idle_plot", int'(plot), 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(i, $sformatf("vec%0d", i));
        end

        // start held high across a whole frame while the grid keeps changing
        pix_cnt = 0;
        grid    = vec[1].grid;
        push_frame(vec[1].cols);
        start = 1'b1;
        wait_done(LAT, "held1", 1'b0, 1'b1);
        frame_end("held1");
        @(negedge clock);
        chk("held_restart_busy", int'(busy), 1);
        start   = 1'b0;
        pix_cnt = 0;
        push_frame(vec[3].cols);
        wait_done(LAT - 1, "held2", 1'b0, 1'b0);
        frame_end("held2");

        // reset asserted part way through a frame
        pix_cnt = 0;
        grid    = vec[3].grid;
        push_frame(vec[3].cols);
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 0;
        while (pix_cnt < 3000 && cyc < 8000) begin
            @(posedge clock);
            #2;
            cyc++;
        end
        chk("midrst_reached_3000", pix_cnt, 3000);
        resetn = 1'b0;
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_x", int'(x), 0);
        repeat (3) @(negedge clock);
        exp_q.delete();
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_idle_busy", int'(busy), 0);
        chk("midrst_no_done", done_cnt, d0);
        run_frame(1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_redraw_ctrl.md
BOARD_REDRAW_CTRL -- requirements
Module: board_redraw_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter TILE_SIZE, default 26: side length in pixels of each drawn cell square; legal range 2..30.
REQ-003 Parameter PITCH, default 30: pixel distance between adjacent cell origins.
REQ-004 clock  input  1  system clock, all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request full-board redraw; sampled only in IDLE.
REQ-007 grid  input  18  board state; cell (r,c) code at bits [2*(3*r+c)+1 : 2*(3*r+c)]; 0 empty, 1 O, 2 X, 3 reserved.
REQ-008 x  output  8  VGA pixel column.
REQ-009 y  output  7  VGA pixel row.
REQ-010 colour  output  3  VGA pixel colour.
REQ-011 plot  output  1  pixel write strobe; x/y/colour valid when high.
REQ-012 busy  output  1  high from start acceptance until done pulse inclusive.
REQ-013 done  output  1  one-cycle pulse at redraw completion.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SETUP, DRAW, DONE.
REQ-015 IDLE: start=1 -> LOAD next cycle; otherwise stay; start ignored in all other states.
REQ-016 LOAD (1 cycle): snapshot grid into internal register; cell index <= 0; -> SETUP. Grid changes after LOAD SHALL not affect the frame.
REQ-017 SETUP (1 cycle): compute origin x0 = 37 + PITCH*c, y0 = 7 + PITCH*r for current cell, clear pixel counters; -> DRAW.
REQ-018 Cell order SHALL be raster: r outer 0..2, c inner 0..2 (index 3*r+c).
REQ-019 DRAW: one pixel per cycle, plot=1, x = x0+px, y = y0+py; px inner 0..TILE_SIZE-1, py outer 0..TILE_SIZE-1.
REQ-020 After pixel (TILE_SIZE-1, TILE_SIZE-1): cell index < 8 -> increment, SETUP; cell index = 8 -> DONE.
REQ-021 DONE (1 cycle): done=1, busy=1, plot=0; -> IDLE.
REQ-022 Colour map: code 0 -> 3'b111 white, 1 -> 3'b011 light blue, 2 -> 3'b101 purple, 3 -> 3'b000 black.
REQ-023 Outputs x, y, colour, plot SHALL be registered; plot=0 in IDLE, LOAD, SETUP, DONE.
REQ-024 Frame latency from start acceptance to done pulse SHALL be 1 + 9*(1 + TILE_SIZE^2) cycles; 6094 at default.
REQ-025 x/y arithmetic SHALL be unsigned, no wrap for legal parameters (max x = 37+2*PITCH+TILE_SIZE-1 <= 159, max y <= 119).

Reset
REQ-026 resetn low SHALL immediately force IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, cell index 0, snapshot 0.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; after release, a new start SHALL redraw from cell 0.

Configuration
REQ-028 Macro BOARD_BORDER_EN defined: pixels with px or py equal to 0 or TILE_SIZE-1 SHALL use colour 3'b000; interior uses REQ-022 map.
REQ-029 BOARD_BORDER_EN undefined: every tile pixel SHALL use the REQ-022 map; timing identical in both builds.

Structure
REQ-030 Shared package board_pkg SHALL hold cell-code constants (EMPTY, O, X), colour constants (WHITE, LBLUE, PURPLE, BLACK), ORIGIN_X0=37, ORIGIN_Y0=7, and the FSM state enum.
REQ-031 One sub-module cell_colour_lut (combinational 2-bit code -> 3-bit colour) SHALL be instantiated.

Verification
REQ-032 All-empty grid, start pulse -> 6084 plot cycles all colour 3'b111, done exactly 6094 cycles after acceptance, busy high throughout.
REQ-033 Grid cell (0,0)=1, (1,1)=2, (2,2)=3, rest 0 -> pixel (37,7) 3'b011, (67,37) 3'b101, (97,67) 3'b000, (67,7) 3'b111; last plot at (122,92).
REQ-034 start held high across entire frame, grid toggled during DRAW -> exactly one frame, colours from LOAD snapshot, new frame begins cycle after DONE.
REQ-035 resetn low at plot count 3000 -> plot=0 and busy=0 same cycle, no done; restart after release produces full 6094-cycle frame.
REQ-036 BOARD_BORDER_EN build, grid all 1 -> (37,7) and (62,32) 3'b000, (38,8) 3'b011; cycle count unchanged.
